rf_wb_queue: RTL and testbench

Write-back queue that sits in front of the 32 x 32-bit register file write port and is the only initiator of register writes. It accepts write requests over a valid/ready handshake, buffers up to DEPTH of them in order, and drains one per cycle onto the register file's write, writereg and data inputs. It also drives bypass data for the two register-file read addresses, so a reader never sees a stale value while a write is still queued.

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_wb_match.sv | 30 +++
 rtl/rf_wb_queue.sv | 124 ++++++++++++
 tb/tb_rf_wb_queue.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the write-back path.
// Provides widths, address/data typedefs and the queued-write entry.
package rf_pkg;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;

    typedef logic [ADDR_W-1:0] rf_addr_t;
    typedef logic [DATA_W-1:0] rf_data_t;

    typedef struct packed {
        rf_addr_t addr;
        rf_data_t data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_match.sv
// Youngest-match priority search over N write candidates for one read port.
// Ports: cand_valid/cand_addr/cand_data (index 0 oldest), addr in; hit, byp out.
module rf_wb_match #(
    parameter int N      = 5,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int DATA_W = rf_pkg::DATA_W
) (
    input  logic [N-1:0]        cand_valid,
    input  logic [N*ADDR_W-1:0] cand_addr,
    input  logic [N*DATA_W-1:0] cand_data,
    input  logic [ADDR_W-1:0]   addr,
    output logic                hit,
    output logic [DATA_W-1:0]   byp
);

    // Later (younger) candidates overwrite earlier matches.
    // Register 0 is hard-wired and never bypassed.
    always_comb begin
        hit = 1'b0;
        byp = '0;
        for (int i = 0; i < N; i++) begin
            if (cand_valid[i] && (addr != '0) &&
                (cand_addr[i*ADDR_W +: ADDR_W] == addr)) begin
                hit = 1'b1;
                byp = cand_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/rf_wb_queue.sv
// In-order write-back queue in front of the register file write port,
// with bypass for two read ports. Ports: in_* handshake, drain_en,
// rf_write/rf_writereg/rf_data, reg1/reg2 -> hit1/hit2/byp1/byp2, count.
module rf_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       drain_en,
    output logic                       rf_write,
    output logic [ADDR_W-1:0]          rf_writereg,
    output logic [DATA_W-1:0]          rf_data,
    input  logic [ADDR_W-1:0]          reg1,
    input  logic [ADDR_W-1:0]          reg2,
    output logic                       hit1,
    output logic                       hit2,
    output logic [DATA_W-1:0]          byp1,
    output logic [DATA_W-1:0]          byp2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int N  = DEPTH + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              push;
    logic              pop;

    logic [N-1:0]        cand_valid;
    logic [N*ADDR_W-1:0] cand_addr;
    logic [N*DATA_W-1:0] cand_data;

    assign in_ready = (count != FULL);
    // Writes to register 0 complete the handshake but are dropped.
    assign push = in_valid && in_ready && (in_addr != '0);
    assign pop  = drain_en && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= in_addr;
            data_mem[tail] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            rf_write    <= 1'b0;
            rf_writereg <= '0;
            rf_data     <= '0;
        end else begin
            rf_write <= pop;
            if (pop) begin
                rf_writereg <= addr_mem[head];
                rf_data     <= data_mem[head];
                head        <= head + 1'b1;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Candidate 0 is the output stage (oldest); queue entries follow
    // from head towards tail, so a higher index is always younger.
    always_comb begin
        cand_valid = '0;
        cand_addr  = '0;
        cand_data  = '0;
        cand_valid[0]          = rf_write;
        cand_addr[0 +: ADDR_W] = rf_writereg;
        cand_data[0 +: DATA_W] = rf_data;
        for (int i = 0; i < DEPTH; i++) begin
            cand_valid[i+1] = (CW'(i) < count);
            cand_addr[(i+1)*ADDR_W +: ADDR_W] = addr_mem[head + PW'(i)];
            cand_data[(i+1)*DATA_W +: DATA_W] = data_mem[head + PW'(i)];
        end
    end

    rf_wb_match #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_match1 (
        .cand_valid (cand_valid),
        .cand_addr  (cand_addr),
        .cand_data  (cand_data),
        .addr       (reg1),
        .hit        (hit1),
        .byp        (byp1)
    );

    rf_wb_match #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_match2 (
        .cand_valid (cand_valid),
        .cand_addr  (cand_addr),
        .cand_data  (cand_data),
        .addr       (reg2),
        .hit        (hit2),
        .byp        (byp2)
    );

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: scoreboard of accepted writes,
// reference model of queue contents for count and bypass expectations.
module tb_rf_wb_queue;
    import rf_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic        drain_en = 1'b0;
    logic        rf_write;
    logic [4:0]  rf_writereg;
    logic [31:0] rf_data;
    logic [4:0]  reg1 = '0;
    logic [4:0]  reg2 = '0;
    logic        hit1, hit2;
    logic [31:0] byp1, byp2;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    wb_entry_t   exp_q[$];
    wb_entry_t   mq[$];
    logic        m_wr = 1'b0;
    logic [4:0]  m_oa = '0;
    logic [31:0] m_od = '0;
    logic        m_full;
    wb_entry_t   m_e;
    wb_entry_t   s_e;
    logic [31:0] rf_mem [32];

    rf_wb_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .drain_en    (drain_en),
        .rf_write    (rf_write),
        .rf_writereg (rf_writereg),
        .rf_data     (rf_data),
        .reg1        (reg1),
        .reg2        (reg2),
        .hit1        (hit1),
        .hit2        (hit2),
        .byp1        (byp1),
        .byp2        (byp2),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Reference model: queue contents and output stage.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            exp_q.delete();
            m_wr = 1'b0;
            m_oa = '0;
            m_od = '0;
        end else begin
            m_full = (mq.size() == DEPTH);
            if (drain_en && mq.size() > 0) begin
                m_wr = 1'b1;
                m_oa = mq[0].addr;
                m_od = mq[0].data;
                void'(mq.pop_front());
            end else begin
                m_wr = 1'b0;
            end
            if (in_valid && !m_full && in_addr != 0) begin
                m_e.addr = in_addr;
                m_e.data = in_data;
                mq.push_back(m_e);
                exp_q.push_back(m_e);
            end
        end
    end

    always @(posedge clk) begin
        if (reset && rf_write) rf_mem[rf_writereg] <= rf_data;
    end

    // Output monitor: every write must be the next accepted request.
    always @(negedge clk) begin
        n_checks++;
        if (rf_write !== m_wr) begin
            n_fail++;
            $display("FAIL mon_rf_write: got %b want %b", rf_write, m_wr);
        end
        n_checks++;
        if (count !== 3'(mq.size())) begin
            n_fail++;
            $display("FAIL mon_count: got %0d want %0d", count, mq.size());
        end
        if (rf_write === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mon_unexpected_write: reg %0d data %0d",
                         rf_writereg, rf_data);
            end else begin
                s_e = exp_q.pop_front();
                if (rf_writereg !== s_e.addr || rf_data !== s_e.data) begin
                    n_fail++;
                    $display("FAIL mon_write: got %0d/%0d want %0d/%0d",
                             rf_writereg, rf_data, s_e.addr, s_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_byp(input logic [4:0] r, output logic h,
                             output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (r != 0) begin
            if (m_wr && m_oa == r) begin
                h = 1'b1;
                d = m_od;
            end
            foreach (mq[i]) begin
                if (mq[i].addr == r) begin
                    h = 1'b1;
                    d = mq[i].data;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1 || rf_write !== 1'b0 || count !== 3'd0 ||
                rf_writereg !== 5'd0 || rf_data !== 32'd0 ||
                hit1 !== 1'b0 || hit2 !== 1'b0 ||
                byp1 !== 32'd0 || byp2 !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_vals: rdy %b wr %b cnt %0d reg %0d",
                         in_ready, rf_write, count, rf_writereg);
            end
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1 || rf_write !== 1'b0 || count !== 3'd0) begin
                n_fail++;
                $display("FAIL idle: rdy %b wr %b cnt %0d want 1 0 0",
                         in_ready, rf_write, count);
            end
            tick();
        end
    endtask

    task automatic test_single_write();
        in_valid = 1'b1;
        in_addr  = 5'd7;
        in_data  = 32'd123;
        drain_en = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rf_write !== 1'b0 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_k: wr %b cnt %0d want 0 1", rf_write, count);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (rf_write !== 1'b1 || rf_writereg !== 5'd7 || rf_data !== 32'd123) begin
            n_fail++;
            $display("FAIL single_k1: %b %0d/%0d want 1 7/123",
                     rf_write, rf_writereg, rf_data);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (rf_write !== 1'b0 || rf_mem[7] !== 32'd123) begin
            n_fail++;
            $display("FAIL single_k2: wr %b rf[7] %0d want 0 123",
                     rf_write, rf_mem[7]);
        end
        drain_en = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        drain_en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_addr  = 5'(i);
            in_data  = 32'(i * 10);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: cnt %0d rdy %b want 4 0", count, in_ready);
        end
        drain_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (rf_write !== 1'b1 || rf_writereg !== 5'(i) ||
                rf_data !== 32'(i * 10)) begin
                n_fail++;
                $display("FAIL fill_drain%0d: %b %0d/%0d want 1 %0d/%0d",
                         i, rf_write, rf_writereg, rf_data, i, i * 10);
            end
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (rf_write !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL fill_done: wr %b cnt %0d want 0 0", rf_write, count);
        end
        drain_en = 1'b0;
    endtask

    task automatic test_bypass();
        drain_en = 1'b0;
        reg1 = 5'd5;
        reg2 = 5'd6;
        in_valid = 1'b1;
        in_addr  = 5'd5;
        in_data  = 32'd100;
        tick();
        in_data  = 32'd200;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hit1 !== 1'b1 || byp1 !== 32'd200 || hit2 !== 1'b0 || byp2 !== 32'd0) begin
            n_fail++;
            $display("FAIL byp_young: %b/%0d %b/%0d want 1/200 0/0",
                     hit1, byp1, hit2, byp2);
        end
        drain_en = 1'b1;
        tick();
        drain_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rf_write !== 1'b1 || hit1 !== 1'b1 || byp1 !== 32'd200) begin
            n_fail++;
            $display("FAIL byp_after_pop: wr %b hit %b byp %0d want 1 1 200",
                     rf_write, hit1, byp1);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (rf_write !== 1'b0 || hit1 !== 1'b1 || byp1 !== 32'd200) begin
            n_fail++;
            $display("FAIL byp_queued: wr %b hit %b byp %0d want 0 1 200",
                     rf_write, hit1, byp1);
        end
        drain_en = 1'b1;
        tick();
        drain_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hit1 !== 1'b1 || byp1 !== 32'd200) begin
            n_fail++;
            $display("FAIL byp_outstage: hit %b byp %0d want 1 200", hit1, byp1);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (hit1 !== 1'b0 || byp1 !== 32'd0) begin
            n_fail++;
            $display("FAIL byp_gone: hit %b byp %0d want 0 0", hit1, byp1);
        end
    endtask

    task automatic test_reg0();
        reg1 = 5'd0;
        reg2 = 5'd0;
        drain_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reg0_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b1;
        in_addr  = 5'd0;
        in_data  = 32'd999;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (count !== 3'd0 || rf_write !== 1'b0 || hit1 !== 1'b0 ||
                hit2 !== 1'b0 || byp1 !== 32'd0 || byp2 !== 32'd0) begin
                n_fail++;
                $display("FAIL reg0: cnt %0d wr %b hit %b%b want 0 0 00",
                         count, rf_write, hit1, hit2);
            end
            tick();
        end
        drain_en = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        drain_en = 1'b0;
        reg1 = 5'd8;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_addr  = 5'(8 + i);
            in_data  = 32'(500 + i);
            tick();
        end
        in_valid = 1'b0;
        drain_en = 1'b1;
        tick();
        drain_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rf_write !== 1'b1 || count !== 3'd3) begin
            n_fail++;
            $display("FAIL rst_pre: wr %b cnt %0d want 1 3", rf_write, count);
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (rf_write !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 ||
            hit1 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: wr %b cnt %0d rdy %b hit %b want 0 0 1 0",
                     rf_write, count, in_ready, hit1);
        end
        tick();
        tick();
        reset = 1'b1;
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (rf_write !== 1'b0 || count !== 3'd0) begin
                n_fail++;
                $display("FAIL rst_after: wr %b cnt %0d want 0 0", rf_write, count);
            end
        end
        drain_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic        eh1, eh2, er;
        logic [31:0] ed1, ed2;
        for (int i = 0; i < 150; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_addr  = 5'($urandom_range(0, 7));
            in_data  = $urandom;
            drain_en = (i < 40) ? 1'b1 : ($urandom_range(0, 2) != 0);
            reg1     = 5'($urandom_range(0, 7));
            reg2     = 5'($urandom_range(0, 7));
            @(negedge clk);
            model_byp(reg1, eh1, ed1);
            model_byp(reg2, eh2, ed2);
            er = (mq.size() != DEPTH);
            n_checks++;
            if (hit1 !== eh1 || byp1 !== ed1 || hit2 !== eh2 || byp2 !== ed2) begin
                n_fail++;
                $display("FAIL b2b_byp%0d: %b/%0d %b/%0d want %b/%0d %b/%0d",
                         i, hit1, byp1, hit2, byp2, eh1, ed1, eh2, ed2);
            end
            n_checks++;
            if (in_ready !== er) begin
                n_fail++;
                $display("FAIL b2b_ready%0d: got %b want %b", i, in_ready, er);
            end
            tick();
        end
        in_valid = 1'b0;
        drain_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        drain_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL b2b_flush: pending %0d cnt %0d want 0 0",
                     exp_q.size(), count);
        end
    endtask

    initial begin
        foreach (rf_mem[i]) rf_mem[i] = '0;
        test_reset();
        test_single_write();
        test_fill();
        test_bypass();
        test_reg0();
        test_reset_mid_drain();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
